// File: rtl/axi4aw_arbiter.sv
// Two-requester round-robin arbiter for one AXI4 AW channel, with a registered
// output slice and a write-order FIFO that tells the W mux which source goes next.
module axi4aw_arbiter #(
  parameter int ORDER_DEPTH = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic [2:0]        s0_awsize,
  input  logic [1:0]        s0_awburst,
  input  logic              s0_awlock,
  input  logic [3:0]        s0_awcache,
  input  logic [2:0]        s0_awprot,
  input  logic [3:0]        s0_awregion,
  input  logic [3:0]        s0_awqos,
  // requester 1
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic [2:0]        s1_awsize,
  input  logic [1:0]        s1_awburst,
  input  logic              s1_awlock,
  input  logic [3:0]        s1_awcache,
  input  logic [2:0]        s1_awprot,
  input  logic [3:0]        s1_awregion,
  input  logic [3:0]        s1_awqos,
  // downstream
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic              m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awlock,
  output logic [3:0]        m_awcache,
  output logic [2:0]        m_awprot,
  output logic [3:0]        m_awregion,
  output logic [3:0]        m_awqos,
  // write-order FIFO
  output logic              wsel_valid,
  output logic              wsel,
  input  logic              wsel_pop,
  output logic              order_full
);

  localparam int PW = $clog2(ORDER_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        region;
    logic [3:0]        qos;
  } aw_t;

  aw_t req0, req1, slice;
  logic last_grant, can_load, gnt_vld, gnt, push, pop;

  logic [ORDER_DEPTH-1:0] order_mem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;

  assign req0 = '{s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock,
                  s0_awcache, s0_awprot, s0_awregion, s0_awqos};
  assign req1 = '{s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock,
                  s1_awcache, s1_awprot, s1_awregion, s1_awqos};

  assign order_full = (count == (PW+1)'(ORDER_DEPTH));
  assign wsel_valid = (count != '0);
  assign wsel       = order_mem[rd_ptr];

  // Slice may take a new beat when empty or draining this cycle, and only if
  // the order FIFO has room to record it.
  assign can_load = (!m_awvalid || m_awready) && !order_full;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (can_load) begin
      unique case ({s1_awvalid, s0_awvalid})
        2'b01:   begin gnt_vld = 1'b1; gnt = 1'b0;        end
        2'b10:   begin gnt_vld = 1'b1; gnt = 1'b1;        end
        2'b11:   begin gnt_vld = 1'b1; gnt = ~last_grant; end
        default: begin gnt_vld = 1'b0; gnt = 1'b0;        end
      endcase
    end
  end

  assign s0_awready = gnt_vld && !gnt;
  assign s1_awready = gnt_vld &&  gnt;
  assign push       = gnt_vld;
  assign pop        = wsel_pop && wsel_valid;

  assign m_awaddr   = slice.addr;
  assign m_awlen    = slice.len;
  assign m_awsize   = slice.size;
  assign m_awburst  = slice.burst;
  assign m_awlock   = slice.lock;
  assign m_awcache  = slice.cache;
  assign m_awprot   = slice.prot;
  assign m_awregion = slice.region;
  assign m_awqos    = slice.qos;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_awvalid  <= 1'b0;
      m_awid     <= 1'b0;
      slice      <= '0;
      last_grant <= 1'b1;
    end else if (gnt_vld) begin
      m_awvalid  <= 1'b1;
      m_awid     <= gnt;
      slice      <= gnt ? req1 : req0;
      last_grant <= gnt;
    end else if (m_awready) begin
      m_awvalid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order_mem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        order_mem[wr_ptr] <= gnt;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_axi4aw_arbiter.sv
// Bench for axi4aw_arbiter: directed table, hand sequences, then random traffic
// compared each cycle against a queue-based reference model.
module tb_axi4aw_arbiter;
  localparam int AW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic s0_awvalid, s0_awready, s0_awlock;
  logic [AW-1:0] s0_awaddr;
  logic [7:0] s0_awlen;
  logic [2:0] s0_awsize, s0_awprot;
  logic [1:0] s0_awburst;
  logic [3:0] s0_awcache, s0_awregion, s0_awqos;
  logic s1_awvalid, s1_awready, s1_awlock;
  logic [AW-1:0] s1_awaddr;
  logic [7:0] s1_awlen;
  logic [2:0] s1_awsize, s1_awprot;
  logic [1:0] s1_awburst;
  logic [3:0] s1_awcache, s1_awregion, s1_awqos;
  logic m_awvalid, m_awready, m_awid, m_awlock;
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize, m_awprot;
  logic [1:0] m_awburst;
  logic [3:0] m_awcache, m_awregion, m_awqos;
  logic wsel_valid, wsel, wsel_pop, order_full;

  axi4aw_arbiter #(.ORDER_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
    .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
    .s0_awlock(s0_awlock), .s0_awcache(s0_awcache), .s0_awprot(s0_awprot),
    .s0_awregion(s0_awregion), .s0_awqos(s0_awqos),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_awlock(s1_awlock), .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
    .s1_awregion(s1_awregion), .s1_awqos(s1_awqos),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awregion(m_awregion), .m_awqos(m_awqos),
    .wsel_valid(wsel_valid), .wsel(wsel), .wsel_pop(wsel_pop),
    .order_full(order_full)
  );

  logic [AW+28:0] m_pay;
  assign m_pay = {m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
                  m_awcache, m_awprot, m_awregion, m_awqos};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slice contents, arbitration history and an order queue.
  bit             mv, mid, last;
  logic [AW+28:0] mpay;
  bit             q[$];

  task automatic model_reset();
    mv = 0; mid = 0; mpay = '0; last = 1; q.delete();
  endtask

  task automatic set_req(input int idx, input bit v, input logic [AW-1:0] a, input logic [7:0] l);
    if (idx == 0) begin
      s0_awvalid = v; s0_awaddr = a; s0_awlen = l;
      s0_awsize = 3'($urandom); s0_awburst = 2'($urandom); s0_awlock = 1'($urandom);
      s0_awcache = 4'($urandom); s0_awprot = 3'($urandom);
      s0_awregion = 4'($urandom); s0_awqos = 4'($urandom);
    end else begin
      s1_awvalid = v; s1_awaddr = a; s1_awlen = l;
      s1_awsize = 3'($urandom); s1_awburst = 2'($urandom); s1_awlock = 1'($urandom);
      s1_awcache = 4'($urandom); s1_awprot = 3'($urandom);
      s1_awregion = 4'($urandom); s1_awqos = 4'($urandom);
    end
  endtask

  // One clock: check in-cycle outputs against the model, clock, advance model.
  task automatic step();
    bit full, cl, gv, g;
    logic [AW+28:0] p0, p1;
    #1;
    full = (q.size() == D);
    cl   = (!mv || m_awready) && !full;
    gv = 0; g = 0;
    if (cl) begin
      if (s0_awvalid && s1_awvalid) begin gv = 1; g = !last; end
      else if (s0_awvalid)          begin gv = 1; g = 0;     end
      else if (s1_awvalid)          begin gv = 1; g = 1;     end
    end
    chk("model s0_awready", 64'(s0_awready), 64'(gv && !g));
    chk("model s1_awready", 64'(s1_awready), 64'(gv && g));
    chk("model order_full", 64'(order_full), 64'(full));
    chk("model wsel_valid", 64'(wsel_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("model wsel", 64'(wsel), 64'(q[0]));
    chk("model m_awvalid", 64'(m_awvalid), 64'(mv));
    chk("model m_awid", 64'(m_awid), 64'(mid));
    chk("model m_payload", 64'(m_pay), 64'(mpay));
    p0 = {s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock,
          s0_awcache, s0_awprot, s0_awregion, s0_awqos};
    p1 = {s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock,
          s1_awcache, s1_awprot, s1_awregion, s1_awqos};
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (wsel_pop && q.size() != 0) void'(q.pop_front());
      if (gv) begin
        q.push_back(g); mv = 1; mid = g; mpay = g ? p1 : p0; last = g;
      end else if (m_awready) mv = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit v0, v1, mr, pop;
    logic [AW-1:0] a0, a1;
    bit r0, r1, mv, mid;
    logic [AW-1:0] maddr;
    bit wv, ws, full;
  } vec_t;

  vec_t tbl[12];
  logic [AW+30:0] snap;

  initial begin
    //        v0 v1 mr pop a0        a1         r0 r1 mv mid maddr      wv ws full
    tbl[0]  = '{1, 0, 1, 0, 32'h1000, 32'h0,    1, 0, 1, 0, 32'h1000, 1, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 32'h2000, 32'h3000, 0, 1, 1, 1, 32'h3000, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 32'h2100, 32'h3100, 1, 0, 1, 0, 32'h2100, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 32'h2200, 32'h3200, 0, 1, 1, 1, 32'h3200, 1, 0, 1};
    tbl[4]  = '{1, 1, 1, 0, 32'h2300, 32'h3300, 0, 0, 0, 1, 32'h3200, 1, 0, 1};
    tbl[5]  = '{1, 1, 1, 1, 32'h2300, 32'h3300, 0, 0, 0, 1, 32'h3200, 1, 1, 0};
    tbl[6]  = '{1, 1, 0, 1, 32'h2300, 32'h3300, 1, 0, 1, 0, 32'h2300, 1, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 32'h2400, 32'h3400, 0, 0, 1, 0, 32'h2300, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 32'h0,    32'h0,    0, 0, 0, 0, 32'h2300, 1, 1, 0};
    tbl[9]  = '{0, 0, 1, 1, 32'h0,    32'h0,    0, 0, 0, 0, 32'h2300, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 32'h0,    32'h0,    0, 0, 0, 0, 32'h2300, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 32'h0,    32'h0,    0, 0, 0, 0, 32'h2300, 0, 0, 0};

    rst = 1; m_awready = 0; wsel_pop = 0;
    set_req(0, 0, '0, '0); set_req(1, 0, '0, '0);
    @(posedge clk); @(negedge clk);
    model_reset();
    #1;
    chk("reset m_awvalid", 64'(m_awvalid), 64'd0);
    chk("reset m_awid", 64'(m_awid), 64'd0);
    chk("reset m_payload", 64'(m_pay), 64'd0);
    chk("reset wsel_valid", 64'(wsel_valid), 64'd0);
    chk("reset wsel", 64'(wsel), 64'd0);
    chk("reset order_full", 64'(order_full), 64'd0);
    chk("reset awready", 64'({s0_awready, s1_awready}), 64'd0);
    rst = 0;

    // Directed table: single request, contention, FIFO fill/stall/drain.
    for (int i = 0; i < 12; i++) begin
      set_req(0, tbl[i].v0, tbl[i].a0, 8'd3);
      set_req(1, tbl[i].v1, tbl[i].a1, 8'd5);
      m_awready = tbl[i].mr; wsel_pop = tbl[i].pop;
      #1;
      chk($sformatf("tbl%0d s0_awready", i), 64'(s0_awready), 64'(tbl[i].r0));
      chk($sformatf("tbl%0d s1_awready", i), 64'(s1_awready), 64'(tbl[i].r1));
      step();
      chk($sformatf("tbl%0d m_awvalid", i), 64'(m_awvalid), 64'(tbl[i].mv));
      chk($sformatf("tbl%0d m_awid", i), 64'(m_awid), 64'(tbl[i].mid));
      chk($sformatf("tbl%0d m_awaddr", i), 64'(m_awaddr), 64'(tbl[i].maddr));
      chk($sformatf("tbl%0d wsel_valid", i), 64'(wsel_valid), 64'(tbl[i].wv));
      if (tbl[i].wv) chk($sformatf("tbl%0d wsel", i), 64'(wsel), 64'(tbl[i].ws));
      chk($sformatf("tbl%0d order_full", i), 64'(order_full), 64'(tbl[i].full));
      if (i == 0) chk("tbl0 m_awlen", 64'(m_awlen), 64'd3);
    end

    // Backpressure: slice must hold for 5 stalled cycles, then reload on ready.
    wsel_pop = 1; m_awready = 0;
    set_req(0, 1, 32'h5000, 8'd1); set_req(1, 0, '0, '0);
    step();
    snap = {m_awvalid, m_awid, m_pay};
    set_req(0, 0, '0, '0); set_req(1, 1, 32'h6000, 8'd7);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp awready", 64'({s0_awready, s1_awready}), 64'd0);
      step();
      chk("bp m_stable", 64'({m_awvalid, m_awid, m_pay}), 64'(snap));
    end
    m_awready = 1;
    #1;
    chk("bp s1_awready", 64'(s1_awready), 64'd1);
    step();
    chk("bp reload valid", 64'(m_awvalid), 64'd1);
    chk("bp reload id", 64'(m_awid), 64'd1);
    chk("bp reload addr", 64'(m_awaddr), 64'h6000);

    // Reset while FULL with two FIFO entries.
    set_req(1, 0, '0, '0); step();
    wsel_pop = 0; m_awready = 1;
    set_req(0, 1, 32'h7000, 8'd2); step();
    set_req(0, 0, '0, '0); set_req(1, 1, 32'h8000, 8'd4); step();
    chk("pre-rst count", 64'(q.size()), 64'd2);
    set_req(1, 0, '0, '0); m_awready = 0; rst = 1;
    step();
    rst = 0;
    chk("rst m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst wsel_valid", 64'(wsel_valid), 64'd0);
    chk("rst wsel", 64'(wsel), 64'd0);
    m_awready = 1;
    set_req(0, 1, 32'h9000, 8'd0); set_req(1, 1, 32'hA000, 8'd0);
    #1;
    chk("post-rst s0 first", 64'({s1_awready, s0_awready}), 64'b01);
    step();
    chk("post-rst m_awid", 64'(m_awid), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set_req(0, $urandom_range(0, 2) != 0, $urandom, 8'($urandom));
      set_req(1, $urandom_range(0, 2) != 0, $urandom, 8'($urandom));
      m_awready = $urandom_range(0, 3) != 0;
      wsel_pop  = $urandom_range(0, 2) == 0;
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4aw_arbiter.md
Name: axi4aw_arbiter

Overview:
Two-requester arbiter for one AXI4 write-address (AW) channel. Requester 0 and requester 1 (for example, core data port and debug/DMA port) compete for a single downstream AW channel. The block applies round-robin arbitration and drives AW from a registered output slice, with m_awid tagging the source. It also pushes each granted source index into a small order FIFO, which the W-channel mux uses to route write data in AW order.

Parameters:
ORDER_DEPTH, 4, entries in the write-order FIFO (power of 2, ≥2)
ADDR_W, 32, address width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sN_awvalid  in  1  requester N (N=0,1) address valid
sN_awready  out  1  requester N accept
sN_awaddr  in  ADDR_W  requester N address
sN_awlen/awsize/awburst/awlock/awcache/awprot/awregion/awqos  in  8/3/2/1/4/3/4/4  requester N AW payload
m_awvalid  out  1  downstream valid
m_awready  in  1  downstream ready
m_awid  out  1  source index of current beat
m_awaddr, m_awlen…m_awqos  out  same widths  registered payload
wsel_valid  out  1  order FIFO non-empty
wsel  out  1  source index at FIFO head
wsel_pop  in  1  W mux finished last beat of head burst
order_full  out  1  order FIFO full

Behaviour:
- Output slice is one register, state EMPTY (m_awvalid=0) or FULL (m_awvalid=1).
- can_load = (EMPTY or (FULL and m_awready)) and not order_full.
- Grant (combinational): if can_load and exactly one sN_awvalid=1, grant that N. If both are valid, grant the index ≠ last_grant.
- sN_awready = can_load and grant==N. Both ready signals are never high together.
- On the accept edge: the payload of N loads into the m_* registers; m_awid←N; last_grant←N; N is pushed to the order FIFO; m_awvalid=1 next cycle. Latency is 1 cycle from sN handshake to m_awvalid.
- FULL with m_awready=0: all m_* outputs hold stable (AXI stability rule). Both sN_awready=0.
- FULL with m_awready=1 and no grant: the slice goes EMPTY, m_awvalid←0.
- FULL with m_awready=1 and a grant: the slice reloads in the same cycle. Back-to-back throughput is one address per cycle.
- The arbiter never withdraws an unaccepted upstream request. Arbitration is re-evaluated every cycle; sN_awvalid staying high is the source's obligation.
- Order FIFO:
  - Push = any sN handshake.
  - Pop = wsel_pop and wsel_valid. wsel_pop while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged, and are legal at count = ORDER_DEPTH−1 or when non-empty.
  - A push is never attempted while full because can_load masks it.
  - Pointers wrap modulo ORDER_DEPTH. The count register is log2(ORDER_DEPTH)+1 bits wide.
  - wsel shows the head entry combinationally from the FIFO memory.
  - wsel_pop depends only on FIFO state, not on AW state.
- Reset (rst=1 at an edge):
  - m_awvalid=0, all m_* payload=0, m_awid=0, sN_awready=0.
  - FIFO empty: wsel_valid=0, wsel=0, order_full=0.
  - last_grant=1, so s0 wins the first contention.
  - Reset mid-transfer discards a pending AW and all FIFO entries with no downstream handshake.

Test Plan:
- Single request: s0 presents addr 0x1000, len 3 with m_awready=1 → s0_awready=1 at cycle 0; m_awvalid=1, m_awid=0, m_awaddr=0x1000, m_awlen=3 at cycle 1; wsel_valid=1, wsel=0.
- Contention: s0 and s1 held valid continuously with m_awready=1 → grants alternate 0,1,0,1 (s0 first after reset), with one accept per cycle and m_awid tracking the grant.
- Backpressure: m_awready=0 for 5 cycles while FULL → m_* stable for all 5 cycles, both sN_awready=0. Raising m_awready with s1 pending gives handshake and reload in the same cycle.
- Order FIFO full: ORDER_DEPTH=4, wsel_pop=0, 4 addresses accepted → order_full=1 and further requests stall. One wsel_pop → one more accept in the next cycle; wsel sequence matches grant order.
- Simultaneous push/pop at count=3 → count stays 3. wsel_pop with FIFO empty → no change, wsel_valid stays 0.
- Reset mid-operation: rst asserted while FULL with 2 FIFO entries → next cycle m_awvalid=0, wsel_valid=0. After release, a contention grants s0 first.
